// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses inst_mem and registers the returned
// word into the IF/ID register. BOOT covers inst_mem's fill cycle; HALT stops at end of memory.
module fetch_unit #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MEM_DEPTH   = 101,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [31:0]       inst_rdata,
    output logic [31:0]       if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              halted
);

    localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [CNT_W-1:0]  boot_cnt_q;
    logic              redirect_ok;

    assign inst_addr   = pc_q;
    assign redirect_ok = (redirect_pc <= LAST_PC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StBoot;
            pc_q       <= ADDR_W'(RESET_PC);
            boot_cnt_q <= '0;
            if_inst    <= '0;
            if_pc      <= '0;
            if_valid   <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state_q)
                StBoot: begin
                    if_inst  <= '0;
                    if_valid <= 1'b0;
                    if (redirect) begin
                        if (redirect_ok) begin
                            pc_q <= redirect_pc;
                        end else begin
                            state_q <= StHalt;
                            halted  <= 1'b1;
                        end
                    end else if (boot_cnt_q == BOOT_LAST) begin
                        state_q <= StRun;
                    end else begin
                        boot_cnt_q <= boot_cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (redirect) begin
                        if_inst  <= '0;
                        if_valid <= 1'b0;
                        if (redirect_ok) begin
                            pc_q <= redirect_pc;
                        end else begin
                            state_q <= StHalt;
                            halted  <= 1'b1;
                        end
                    end else if (flush) begin
                        // PC is not advanced so the squashed word is refetched
                        if_inst  <= '0;
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        if_inst  <= inst_rdata;
                        if_pc    <= pc_q;
                        if_valid <= 1'b1;
                        if (pc_q == LAST_PC) begin
                            state_q <= StHalt;
                            halted  <= 1'b1;
                        end else begin
                            pc_q <= pc_q + 1'b1;
                        end
                    end
                end
                StHalt: begin
                    if_inst  <= '0;
                    if_valid <= 1'b0;
                    if (redirect && redirect_ok) begin
                        pc_q    <= redirect_pc;
                        state_q <= StRun;
                        halted  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StBoot;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a combinational inst_mem model feeds the DUT and each
// vector is checked just after the rising edge against hand-computed values.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redirect;
    logic [31:0] redirect_pc, inst_addr, inst_rdata, if_inst, if_pc;
    logic        if_valid, halted;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .if_valid   (if_valid),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   mem_word = 32'h0000_0000;
            32'd1:   mem_word = 32'h4C00_007B;
            32'd2:   mem_word = 32'h4C20_0159;
            32'd6:   mem_word = 32'h0423_1000;
            default: mem_word = 32'hC0DE_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    always_comb inst_rdata = mem_word(inst_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic rd,
                         input logic [31:0] rpc);
        rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_inst", if_inst, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_addr", inst_addr, 32'd0);

        // 1: one boot cycle, then sequential fetch
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        check("boot_valid", {31'd0, if_valid}, 32'd0);
        check("boot_addr", inst_addr, 32'd0);
        step();
        check("f0_pc", if_pc, 32'd0);
        check("f0_inst", if_inst, 32'h0000_0000);
        check("f0_valid", {31'd0, if_valid}, 32'd1);
        step();
        check("f1_pc", if_pc, 32'd1);
        check("f1_inst", if_inst, 32'h4C00_007B);
        step();
        check("f2_pc", if_pc, 32'd2);
        check("f2_inst", if_inst, 32'h4C20_0159);
        check("f2_addr", inst_addr, 32'd3);

        // 2: stall two cycles
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_addr", inst_addr, 32'd3);
            check("stall_pc", if_pc, 32'd2);
            check("stall_inst", if_inst, 32'h4C20_0159);
            check("stall_valid", {31'd0, if_valid}, 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        check("unstall_pc", if_pc, 32'd3);
        check("unstall_inst", if_inst, mem_word(32'd3));

        // flush alone: squash, PC held
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        step();
        check("flush_valid", {31'd0, if_valid}, 32'd0);
        check("flush_inst", if_inst, 32'd0);
        check("flush_pc", if_pc, 32'd3);
        check("flush_addr", inst_addr, 32'd4);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        check("refetch_pc", if_pc, 32'd4);
        check("refetch_valid", {31'd0, if_valid}, 32'd1);

        // 3: redirect wins over flush and stall
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd6);
        step();
        check("redir_valid", {31'd0, if_valid}, 32'd0);
        check("redir_inst", if_inst, 32'd0);
        check("redir_addr", inst_addr, 32'd6);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        check("redir6_pc", if_pc, 32'd6);
        check("redir6_inst", if_inst, 32'h0423_1000);

        // 4: run off the end of memory
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd99);
        step();
        check("r99_addr", inst_addr, 32'd99);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        check("f99_pc", if_pc, 32'd99);
        step();
        check("f100_pc", if_pc, 32'd100);
        check("f100_valid", {31'd0, if_valid}, 32'd1);
        check("f100_inst", if_inst, mem_word(32'd100));
        check("f100_addr", inst_addr, 32'd100);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, i[0], i[1], 1'b0, 32'd0);
            step();
            check("halt_valid", {31'd0, if_valid}, 32'd0);
            check("halt_inst", if_inst, 32'd0);
            check("halt_halted", {31'd0, halted}, 32'd1);
            check("halt_addr", inst_addr, 32'd100);
        end

        // 5: leave HALT, then out-of-range redirect, then recover
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd10);
        step();
        check("exit_halted", {31'd0, halted}, 32'd0);
        check("exit_addr", inst_addr, 32'd10);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd200);
        step();
        check("oor_addr", inst_addr, 32'd10);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        check("oor_halted", {31'd0, halted}, 32'd1);
        check("oor_addr2", inst_addr, 32'd10);
        check("oor_valid", {31'd0, if_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
        step();
        check("rec_halted", {31'd0, halted}, 32'd0);
        check("rec_addr", inst_addr, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        check("rec_pc", if_pc, 32'd1);
        check("rec_inst", if_inst, 32'h4C00_007B);
        check("rec_valid", {31'd0, if_valid}, 32'd1);
        step();

        // 6: reset beats redirect and stall mid-run
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'd50);
        step();
        check("rst2_addr", inst_addr, 32'd0);
        check("rst2_valid", {31'd0, if_valid}, 32'd0);
        check("rst2_inst", if_inst, 32'd0);
        check("rst2_halted", {31'd0, halted}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        check("boot2_valid", {31'd0, if_valid}, 32'd0);
        check("boot2_addr", inst_addr, 32'd0);
        step();
        check("boot2_f0_pc", if_pc, 32'd0);
        check("boot2_f0_valid", {31'd0, if_valid}, 32'd1);
        check("boot2_addr1", inst_addr, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
